// File: rtl/conv_frame_ctrl.sv
// Frame sequencer: streams one IX*IY frame from pixel memory into the 5x5 line buffer, counts returned windows.
// Optional CONV_FRAME_CTRL_AUTO_RESTART_EN: DONE re-enters LOAD directly when i_start is held.
module conv_frame_ctrl #(
  parameter int I_F_BW    = 8,
  parameter int IX        = 28,
  parameter int IY        = 28,
  parameter int KX        = 5,
  parameter int KY        = 5,
  parameter int DRAIN_MAX = 64,
  localparam int NPIX     = IX * IY,
  localparam int EXP_WIN  = (IX - KX + 1) * (IY - KY + 1),
  localparam int AW       = $clog2(NPIX),
  localparam int WW       = $clog2(EXP_WIN + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_start,
  input  logic              i_stall,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_mem_rd_en,
  output logic [AW-1:0]     o_mem_addr,
  input  logic [I_F_BW-1:0] i_mem_rd_data,
  output logic              o_lb_valid,
  output logic [I_F_BW-1:0] o_lb_pixel,
  input  logic              i_win_valid,
  output logic [WW-1:0]     o_win_cnt
);

  localparam int DW = $clog2(DRAIN_MAX + 1);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(NPIX - 1);
  localparam logic [WW-1:0] WIN_FULL   = WW'(EXP_WIN);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_MAX - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] addr, addr_nxt;
  logic [WW-1:0] win_cnt, win_cnt_nxt;
  logic [DW-1:0] drain_cnt, drain_cnt_nxt;
  logic          err, err_nxt;
  logic          rd_en;
  logic          lb_valid;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      addr      <= '0;
      win_cnt   <= '0;
      drain_cnt <= '0;
      err       <= 1'b0;
      lb_valid  <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      win_cnt   <= win_cnt_nxt;
      drain_cnt <= drain_cnt_nxt;
      err       <= err_nxt;
      lb_valid  <= rd_en;
    end
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr;
    win_cnt_nxt   = win_cnt;
    drain_cnt_nxt = drain_cnt;
    err_nxt       = err;
    rd_en         = 1'b0;

    if ((state == LOAD || state == DRAIN) && i_win_valid && win_cnt != WIN_FULL)
      win_cnt_nxt = win_cnt + 1'b1;

    case (state)
      IDLE: begin
        if (i_start) begin
          state_nxt     = LOAD;
          addr_nxt      = '0;
          win_cnt_nxt   = '0;
          drain_cnt_nxt = '0;
          err_nxt       = 1'b0;
        end
      end
      LOAD: begin
        if (!i_stall) begin
          rd_en = 1'b1;
          // Wrap to 0 on the last issue so the counter never leaves the frame.
          if (addr == LAST_ADDR) begin
            addr_nxt      = '0;
            drain_cnt_nxt = '0;
            state_nxt     = DRAIN;
          end else begin
            addr_nxt = addr + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (win_cnt == WIN_FULL) begin
          state_nxt = DONE;
        end else if (drain_cnt == DRAIN_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = DONE;
        end else begin
          drain_cnt_nxt = drain_cnt + 1'b1;
        end
      end
      DONE: begin
`ifdef CONV_FRAME_CTRL_AUTO_RESTART_EN
        if (i_start) begin
          state_nxt     = LOAD;
          addr_nxt      = '0;
          win_cnt_nxt   = '0;
          drain_cnt_nxt = '0;
          err_nxt       = 1'b0;
        end else begin
          state_nxt = IDLE;
        end
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_busy      = (state != IDLE);
  assign o_done      = (state == DONE);
  assign o_err       = err;
  assign o_mem_rd_en = rd_en;
  assign o_mem_addr  = addr;
  assign o_lb_valid  = lb_valid;
  assign o_lb_pixel  = i_mem_rd_data;
  assign o_win_cnt   = win_cnt;

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Self-checking bench for conv_frame_ctrl: memory and line-buffer models, table of frame scenarios, corner sequences.
module tb_conv_frame_ctrl;

  localparam int I_F_BW = 8, IX = 28, IY = 28, KX = 5, KY = 5, DRAIN_MAX = 64;
  localparam int NPIX = IX * IY;
  localparam int EXP_WIN = (IX - KX + 1) * (IY - KY + 1);
  localparam int AW = $clog2(NPIX);
  localparam int WW = $clog2(EXP_WIN + 1);

  logic clk, reset_n, i_start, i_stall, i_win_valid, lb_win, win_inject;
  logic o_busy, o_done, o_err, o_mem_rd_en, o_lb_valid;
  logic [AW-1:0] o_mem_addr;
  logic [I_F_BW-1:0] i_mem_rd_data, o_lb_pixel;
  logic [WW-1:0] o_win_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign i_win_valid = lb_win | win_inject;

  conv_frame_ctrl #(.I_F_BW(I_F_BW), .IX(IX), .IY(IY), .KX(KX), .KY(KY), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_stall(i_stall),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_mem_rd_en(o_mem_rd_en),
    .o_mem_addr(o_mem_addr), .i_mem_rd_data(i_mem_rd_data), .o_lb_valid(o_lb_valid),
    .o_lb_pixel(o_lb_pixel), .i_win_valid(i_win_valid), .o_win_cnt(o_win_cnt)
  );

  // Synchronous pixel memory: data one cycle after the read strobe.
  logic [I_F_BW-1:0] mem [NPIX];
  always @(posedge clk) if (o_mem_rd_en) i_mem_rd_data <= mem[o_mem_addr];

  // Line buffer model: a window completes whenever a pixel with x>=KX-1 and y>=KY-1 arrives.
  function automatic bit win_at(int k);
    return ((k % IX) >= KX - 1) && ((k / IX) >= KY - 1);
  endfunction

  int lb_idx, win_sent, win_limit;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lb_idx <= 0; win_sent <= 0; lb_win <= 1'b0;
    end else begin
      lb_win <= 1'b0;
      if (o_lb_valid) begin
        if (lb_idx == 0) win_sent <= 0;
        else if (win_at(lb_idx) && win_sent < win_limit) begin
          lb_win <= 1'b1; win_sent <= win_sent + 1;
        end
        lb_idx <= (lb_idx == NPIX - 1) ? 0 : lb_idx + 1;
      end
    end
  end

  // Monitor on the falling edge.
  int beats[$];
  int addrs[$];
  int cyc, done_pulses, last_rd_cyc, done_cyc, last_beat_cyc;
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (o_lb_valid) begin beats.push_back(int'(o_lb_pixel)); last_beat_cyc = cyc; end
    if (o_mem_rd_en) begin addrs.push_back(int'(o_mem_addr)); last_rd_cyc = cyc; end
    if (o_done) begin done_pulses = done_pulses + 1; done_cyc = cyc; end
  end

  int n_checks, n_errors;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic randomize_mem();
    for (int k = 0; k < NPIX; k++) mem[k] = I_F_BW'($urandom);
  endtask

  // Expected stream: nfr frames of mem[0..NPIX-1] in address order, regardless of stalls.
  task automatic check_stream(input string name, input int b_beats, input int b_addrs, input int nfr);
    int bad_pix, bad_addr, nb, na;
    bad_pix = 0; bad_addr = 0;
    nb = beats.size() - b_beats; na = addrs.size() - b_addrs;
    check({name, "_beats"}, nb, nfr * NPIX);
    check({name, "_reads"}, na, nfr * NPIX);
    for (int k = 0; k < nb && k < nfr * NPIX; k++)
      if (beats[b_beats + k] != int'(mem[k % NPIX])) bad_pix++;
    for (int k = 0; k < na && k < nfr * NPIX; k++)
      if (addrs[b_addrs + k] != k % NPIX) bad_addr++;
    check({name, "_pix_mismatches"}, bad_pix, 0);
    check({name, "_addr_mismatches"}, bad_addr, 0);
  endtask

  task automatic run_frame(input int stall_addr, input int stall_len, input bit rnd, input bit poke,
                           output bit ok);
    int stalled, cycles;
    stalled = 0; ok = 1'b0;
    i_start = 1'b1; tick(); i_start = 1'b0;
    for (cycles = 0; cycles < 5000; cycles++) begin
      if (o_busy && int'(o_mem_addr) == stall_addr && stalled < stall_len) begin
        i_stall = 1'b1; stalled++;
      end else begin
        i_stall = rnd ? ($urandom_range(3) == 0) : 1'b0;
      end
      i_start = poke && (cycles == 200);
      tick();
      if (!o_busy) begin ok = 1'b1; break; end
    end
    i_stall = 1'b0; i_start = 1'b0;
  endtask

  typedef struct {
    int stall_addr; int stall_len; bit rnd; bit poke; int win_limit; int exp_win; bit exp_err;
  } vec_t;

  initial begin
    vec_t vt[7];
    int b_beats, b_addrs, b_done, first_rd, seen, bad;
    bit ok;
    vt[0] = '{-1,  0, 1'b0, 1'b0, EXP_WIN,     EXP_WIN,     1'b0};
    vt[1] = '{100, 10, 1'b0, 1'b0, EXP_WIN,     EXP_WIN,     1'b0};
    vt[2] = '{783,  1, 1'b0, 1'b0, EXP_WIN,     EXP_WIN,     1'b0};
    vt[3] = '{-1,  0, 1'b1, 1'b1, EXP_WIN,     EXP_WIN,     1'b0};
    vt[4] = '{-1,  0, 1'b0, 1'b0, 500,         500,         1'b1};
    vt[5] = '{-1,  0, 1'b1, 1'b0, EXP_WIN - 1, EXP_WIN - 1, 1'b1};
    vt[6] = '{-1,  0, 1'b1, 1'b1, EXP_WIN,     EXP_WIN,     1'b0};

    reset_n = 1'b0; i_start = 1'b0; i_stall = 1'b0; win_inject = 1'b0; win_limit = EXP_WIN;
    #1;
    check("rst_busy", o_busy, 0);  check("rst_done", o_done, 0);
    check("rst_err", o_err, 0);    check("rst_rd_en", o_mem_rd_en, 0);
    check("rst_addr", o_mem_addr, 0); check("rst_lb_valid", o_lb_valid, 0);
    check("rst_win_cnt", o_win_cnt, 0);
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Latency: start at edge N, read at N+1, first beat at N+2, last beat NPIX after first read.
    randomize_mem();
    b_beats = beats.size(); b_addrs = addrs.size();
    i_start = 1'b1; tick(); i_start = 1'b0;
    first_rd = cyc + 1;
    check("lat_busy", o_busy, 1);      check("lat_rd_en", o_mem_rd_en, 1);
    check("lat_addr0", o_mem_addr, 0); check("lat_no_beat_yet", o_lb_valid, 0);
    tick();
    check("lat_first_beat", o_lb_valid, 1); check("lat_pix0", o_lb_pixel, mem[0]);
    check("lat_addr1", o_mem_addr, 1);
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin tick(); if (!o_busy) begin ok = 1'b1; break; end end
    check("lat_frame_done", ok, 1);
    check("lat_last_beat", last_beat_cyc - first_rd, NPIX);
    check_stream("lat", b_beats, b_addrs, 1);

    for (int v = 0; v < 7; v++) begin
      randomize_mem();
      win_limit = vt[v].win_limit;
      b_beats = beats.size(); b_addrs = addrs.size(); b_done = done_pulses;
      run_frame(vt[v].stall_addr, vt[v].stall_len, vt[v].rnd, vt[v].poke, ok);
      repeat (2) tick();
      check($sformatf("v%0d_completed", v), ok, 1);
      check_stream($sformatf("v%0d", v), b_beats, b_addrs, 1);
      check($sformatf("v%0d_done_pulses", v), done_pulses - b_done, 1);
      check($sformatf("v%0d_err", v), o_err, vt[v].exp_err);
      check($sformatf("v%0d_win_cnt", v), o_win_cnt, vt[v].exp_win);
      check($sformatf("v%0d_busy_low", v), o_busy, 0);
      if (vt[v].exp_err)
        check($sformatf("v%0d_watchdog_timing", v), done_cyc - last_rd_cyc, DRAIN_MAX + 1);
    end

    // Reset in the middle of a frame.
    randomize_mem(); win_limit = EXP_WIN;
    i_start = 1'b1; tick(); i_start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (int'(o_mem_addr) == 300) begin ok = 1'b1; break; end
      tick();
    end
    check("mid_reached_300", ok, 1);
    reset_n = 1'b0; #1;
    check("mid_busy", o_busy, 0);    check("mid_done", o_done, 0);
    check("mid_err", o_err, 0);      check("mid_rd_en", o_mem_rd_en, 0);
    check("mid_addr", o_mem_addr, 0); check("mid_lb_valid", o_lb_valid, 0);
    check("mid_win_cnt", o_win_cnt, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    // Window strobes in IDLE are ignored, and nothing streams without a start.
    bad = 0; win_inject = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (o_mem_rd_en || o_lb_valid || o_busy) bad++;
      if (c == 2) win_inject = 1'b0;
    end
    check("idle_quiet_cycles", bad, 0);
    check("idle_win_ignored", o_win_cnt, 0);
    b_beats = beats.size(); b_addrs = addrs.size();
    run_frame(-1, 0, 1'b0, 1'b0, ok);
    repeat (2) tick();
    check("post_rst_completed", ok, 1);
    check_stream("post_rst", b_beats, b_addrs, 1);
    check("post_rst_win_cnt", o_win_cnt, EXP_WIN);

    // Holding i_start through DONE.
    randomize_mem(); win_limit = EXP_WIN;
    b_beats = beats.size(); b_addrs = addrs.size(); b_done = done_pulses;
    seen = 0; ok = 1'b0;
    i_start = 1'b1; tick();
`ifdef CONV_FRAME_CTRL_AUTO_RESTART_EN
    for (int c = 0; c < 6000; c++) begin
      if (o_done) seen++;
      if (seen == 2) i_start = 1'b0;
      tick();
      if (!o_busy) begin ok = 1'b1; break; end
    end
    repeat (2) tick();
    check("auto_completed", ok, 1);
    check("auto_busy_continuous", seen, 2);
    check("auto_done_pulses", done_pulses - b_done, 2);
    check_stream("auto", b_beats, b_addrs, 2);
`else
    for (int c = 0; c < 3000; c++) begin
      if (o_done) begin seen = 1; break; end
      tick();
    end
    check("hold_done_seen", seen, 1);
    tick();
    check("hold_back_to_idle", o_busy, 0);
    i_start = 1'b0;
    repeat (3) tick();
    check("hold_stays_idle", o_busy, 0);
    check("hold_done_pulses", done_pulses - b_done, 1);
    check_stream("hold", b_beats, b_addrs, 1);
`endif
    i_start = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
